// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array core and its result drain.
// Defaults, drain FSM states and the accumulator element type.
package sa_pkg;

    localparam int N_DEF     = 3;
    localparam int ACC_DEF   = 32;
    localparam int OUT_W_DEF = 8;

    typedef enum logic {
        IDLE,
        STREAM
    } drain_state_e;

    typedef logic signed [ACC_DEF-1:0] acc_t;

endpackage

// File: rtl/sa_result_drain_if.sv
// Valid/ready element stream from the result drain.
// Each beat carries one requantized element and its matrix position.
interface sa_result_drain_if #(
    parameter int OUT_W = 8,
    parameter int RW    = 2
);

    logic                    m_valid;
    logic                    m_ready;
    logic signed [OUT_W-1:0] m_data;
    logic [RW-1:0]           m_row;
    logic [RW-1:0]           m_col;
    logic                    m_last;

    modport master (
        output m_valid, m_data, m_row, m_col, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_row, m_col, m_last,
        output m_ready
    );

endinterface

// File: rtl/sa_requant.sv
// Requantizer: rounding arithmetic right shift, optional ReLU,
// saturation to OUT_W. Purely combinational.
module sa_requant #(
    parameter int ACC   = 32,
    parameter int OUT_W = 8
) (
    input  logic signed [ACC-1:0]   x,
    input  logic [4:0]              shift,
    input  logic                    relu,
    output logic signed [OUT_W-1:0] y
);

    // One guard bit keeps the rounding add from overflowing.
    localparam logic signed [ACC:0] MAXV = (ACC+1)'((1 <<< (OUT_W-1)) - 1);
    localparam logic signed [ACC:0] MINV = ~MAXV;

    logic signed [ACC:0] xe;
    logic signed [ACC:0] half;
    logic signed [ACC:0] r;

    // Round half up, clamp negatives if asked, then saturate.
    always_comb begin
        xe   = {x[ACC-1], x};
        half = '0;
        r    = xe;
        if (shift != 5'd0) begin
            half = (ACC+1)'(1) << (shift - 5'd1);
            r    = (xe + half) >>> shift;
        end
        if (relu && r[ACC]) begin
            r = '0;
        end
        if (r > MAXV) begin
            y = MAXV[OUT_W-1:0];
        end else if (r < MINV) begin
            y = MINV[OUT_W-1:0];
        end else begin
            y = r[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/sa_result_drain.sv
// Snapshots the result matrix on a rising done and streams it out
// row-major, requantized, while the core moves on to the next tile.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC   = ACC_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int RW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          done,
    input  logic [N-1:0][N-1:0][ACC-1:0]  c_in,
    input  logic [4:0]                    cfg_shift,
    input  logic                          cfg_relu,
    output logic                          busy,
    output logic                          overrun,
    sa_result_drain_if.master             m
);

    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;

    drain_state_e state_q, state_d;

    logic                    done_q;
    logic                    done_rise;
    logic [ACC-1:0]          tile_q [NN];
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           nidx;
    logic                    at_last;
    logic                    hs;
    logic                    capture;
    logic                    advance;
    logic signed [ACC-1:0]   rq_x;
    logic [4:0]              rq_shift;
    logic                    rq_relu;
    logic signed [OUT_W-1:0] rq_y;

    assign done_rise = done & ~done_q;
    assign at_last   = (idx_q == IW'(NN - 1));
    assign nidx      = at_last ? '0 : idx_q + IW'(1);
    assign hs        = m.m_valid & m.m_ready;
    assign busy      = (state_q == STREAM);
    assign m.m_valid = (state_q == STREAM);

    // On capture the first element comes straight from c_in and cfg.
    assign rq_x     = capture ? c_in[0][0] : tile_q[nidx];
    assign rq_shift = capture ? cfg_shift : shift_q;
    assign rq_relu  = capture ? cfg_relu : relu_q;

    sa_requant #(
        .ACC   (ACC),
        .OUT_W (OUT_W)
    ) u_requant (
        .x     (rq_x),
        .shift (rq_shift),
        .relu  (rq_relu),
        .y     (rq_y)
    );

    // State register and done edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done;
        end
    end

    // Next state plus capture/advance strobes.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (done_rise) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (at_last) begin
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tile snapshot, flattened row-major; never reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NN; i++) begin
                tile_q[i] <= c_in[i / N][i % N];
            end
        end
    end

    // Index, latched config, output beat registers and overrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            m.m_data <= '0;
            m.m_row  <= '0;
            m.m_col  <= '0;
            m.m_last <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= done_rise & (state_q == STREAM);
            if (capture) begin
                idx_q    <= '0;
                shift_q  <= cfg_shift;
                relu_q   <= cfg_relu;
                m.m_data <= rq_y;
                m.m_row  <= '0;
                m.m_col  <= '0;
                m.m_last <= (NN == 1);
            end else if (advance) begin
                idx_q    <= nidx;
                m.m_data <= rq_y;
                m.m_last <= (nidx == IW'(NN - 1));
                if (m.m_col == RW'(N - 1)) begin
                    m.m_col <= '0;
                    m.m_row <= m.m_row + RW'(1);
                end else begin
                    m.m_col <= m.m_col + RW'(1);
                end
            end else if (hs) begin
                m.m_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: stimulus pushes hand-computed
// beats, a monitor compares every presented beat against the queue head.
module tb_sa_result_drain;

    logic                      clk;
    logic                      rst_n;
    logic                      done;
    logic [2:0][2:0][31:0]     c_in;
    logic [4:0]                cfg_shift;
    logic                      cfg_relu;
    logic                      busy;
    logic                      overrun;

    sa_result_drain_if #(.OUT_W(8), .RW(2)) mif ();

    sa_result_drain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done      (done),
        .c_in      (c_in),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .busy      (busy),
        .overrun   (overrun),
        .m         (mif.master)
    );

    typedef struct {
        logic signed [7:0] d;
        logic [1:0]        r;
        logic [1:0]        c;
        logic              l;
    } beat_t;

    beat_t exp_q[$];
    int    vecs;
    int    errs;
    int    hs_count;
    int    ov_count;
    bit    rdy_rand;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer: always ready, or a coin flip each cycle.
    always @(posedge clk) begin
        #1;
        mif.m_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
    end

    // Monitor: check every presented beat against the queue head.
    always @(negedge clk) begin
        if (rst_n && mif.m_valid) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL extra_beat data=%0d row=%0d col=%0d",
                         mif.m_data, mif.m_row, mif.m_col);
            end else if (mif.m_data !== exp_q[0].d ||
                         mif.m_row !== exp_q[0].r ||
                         mif.m_col !== exp_q[0].c ||
                         mif.m_last !== exp_q[0].l) begin
                errs++;
                $display("FAIL beat got d=%0d r=%0d c=%0d l=%0b want d=%0d r=%0d c=%0d l=%0b",
                         mif.m_data, mif.m_row, mif.m_col, mif.m_last,
                         exp_q[0].d, exp_q[0].r, exp_q[0].c, exp_q[0].l);
            end
            if (mif.m_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                hs_count++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && overrun) ov_count++;
    end

    task automatic chk(input string name, input int act, input int want);
        vecs++;
        if (act != want) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic push_exp(input int e[9]);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back('{d: 8'(e[i]), r: 2'(i / 3),
                              c: 2'(i % 3), l: (i == 8)});
        end
    endtask

    task automatic load_tile(input int t[9], input logic [4:0] sh,
                             input logic rl);
        for (int i = 0; i < 9; i++) c_in[i / 3][i % 3] = 32'(t[i]);
        cfg_shift = sh;
        cfg_relu  = rl;
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 9; i++) c_in[i / 3][i % 3] = 32'h8000_0123;
        cfg_shift = 5'd9;
        cfg_relu  = ~cfg_relu;
    endtask

    // Called at posedge+1: pulse done for one cycle.
    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic run_tile(input string name, input int t[9],
                            input int e[9], input logic [4:0] sh,
                            input logic rl);
        load_tile(t, sh, rl);
        push_exp(e);
        pulse_done();
        chk({name, "_first_valid"}, int'(mif.m_valid), 1);
        scramble_inputs();
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_idle"}, int'(ok), 1);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_hs(input string name, input int target);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (hs_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_hs_reached"}, int'(ok), 1);
    endtask

    initial begin
        int t1[9];
        int e1[9];
        int t2[9];
        int e2[9];
        int e3[9];
        int t4[9];
        int e4[9];
        int t5a[9];
        int t5b[9];
        int t6[9];
        int base;
        int ov0;
        int vcnt;

        vecs      = 0;
        errs      = 0;
        hs_count  = 0;
        ov_count  = 0;
        rdy_rand  = 1'b0;
        rst_n     = 1'b0;
        done      = 1'b0;
        cfg_shift = 5'd0;
        cfg_relu  = 1'b0;
        c_in      = '0;

        t1  = '{7, 0, 0, 0, 7, 0, 0, 0, 7};
        e1  = '{7, 0, 0, 0, 7, 0, 0, 0, 7};
        t2  = '{1000, -1000, 6, 0, 0, 0, 0, 0, 0};
        e2  = '{127, -128, 2, 0, 0, 0, 0, 0, 0};
        e3  = '{127, 0, 2, 0, 0, 0, 0, 0, 0};
        t4  = '{-5, -3, -1, 1, 3, 5, 7, 9, 300};
        e4  = '{-2, -1, 0, 1, 2, 3, 4, 5, 127};
        t5a = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        t5b = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
        t6  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", int'(mif.m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_last", int'(mif.m_last), 0);
        chk("rst_data", int'(mif.m_data), 0);
        chk("rst_row", int'(mif.m_row), 0);
        chk("rst_col", int'(mif.m_col), 0);

        // T1: identity times 7, pass-through.
        run_tile("t1", t1, e1, 5'd0, 1'b0);
        wait_idle("t1");
        chk("t1_valid_low", int'(mif.m_valid), 0);

        // T2: rounding shift with saturation.
        run_tile("t2", t2, e2, 5'd2, 1'b0);
        wait_idle("t2");

        // T3: same tile with ReLU.
        run_tile("t3", t2, e3, 5'd2, 1'b1);
        wait_idle("t3");

        // T4: random back-pressure; stalls checked against queue head.
        rdy_rand = 1'b1;
        base = hs_count;
        run_tile("t4", t4, e4, 5'd1, 1'b0);
        wait_idle("t4");
        chk("t4_handshakes", hs_count - base, 9);
        rdy_rand = 1'b0;

        // T5: done rise mid-drain is dropped, later rise captures.
        ov0  = ov_count;
        base = hs_count;
        run_tile("t5a", t5a, t5a, 5'd0, 1'b0);
        wait_hs("t5", base + 3);
        @(posedge clk);
        #1;
        load_tile(t5b, 5'd0, 1'b0);
        pulse_done();
        wait_idle("t5a");
        chk("t5_overrun_once", ov_count - ov0, 1);
        run_tile("t5b", t5b, t5b, 5'd0, 1'b0);
        wait_idle("t5b");
        chk("t5_overrun_total", ov_count - ov0, 1);

        // T6: async reset during beat 5.
        base = hs_count;
        run_tile("t6", t6, t6, 5'd0, 1'b0);
        wait_hs("t6", base + 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async", int'(mif.m_valid), 0);
        chk("t6_busy_async", int'(busy), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (mif.m_valid) vcnt++;
        end
        chk("t6_no_resume", vcnt, 0);
        @(posedge clk);
        #1;
        run_tile("t6b", t1, e1, 5'd0, 1'b0);
        wait_idle("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
